// File: rtl/frame_addr_pkg.sv
// Shared frame-buffer address layout for the SDRAM read and write paths.
// Also holds the state type used by the read-side sequencer.
package frame_addr_pkg;

  localparam int BANK_WIDTH  = 2;
  localparam int ROW_WIDTH   = 13;
  localparam int COL_WIDTH   = 9;
  localparam int HADDR_WIDTH = 24;

  localparam logic [BANK_WIDTH-1:0] FB_BANK = 2'b01;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LINE = 2'd1,
    ISSUE     = 2'd2,
    DRAIN     = 2'd3
  } rd_state_e;

  function automatic logic [HADDR_WIDTH-1:0] pack_haddr(
    input logic [BANK_WIDTH-1:0] bank,
    input logic [ROW_WIDTH-1:0]  row,
    input logic [COL_WIDTH-1:0]  col
  );
    return {bank, row, col};
  endfunction

endpackage

// File: rtl/frame_addr_reader_credit.sv
// Saturating count of accepted-but-uncompleted read bursts.
// has_credit looks ahead to the count after this cycle's inc/dec.
module rd_credit_counter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic has_credit,
  output logic empty
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  logic [3:0] count_r;
  logic [3:0] count_nxt_s;

  // next count: up on inc, down on dec, unchanged on both, clamped at 0 and MAX
  always_comb begin
    count_nxt_s = count_r;
    case ({inc, dec})
      2'b10: begin
        if (count_r < MAX_CNT) count_nxt_s = count_r + 4'd1;
        else                   count_nxt_s = count_r;
      end
      2'b01: begin
        if (count_r != 4'd0) count_nxt_s = count_r - 4'd1;
        else                 count_nxt_s = count_r;
      end
      default: count_nxt_s = count_r;
    endcase
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_r <= 4'd0;
    else     count_r <= count_nxt_s;
  end

  assign has_credit = (count_nxt_s < MAX_CNT);
  assign empty      = (count_r == 4'd0);

endmodule

// File: rtl/frame_addr_reader.sv
// Read-side burst address sequencer for the VGA frame buffer in SDRAM.
// Walks each requested line in BURST_LEN steps with a bounded number of bursts in flight.
module frame_addr_reader
  import frame_addr_pkg::*;
#(
  parameter int H_WORDS         = 320,
  parameter int V_LINES         = 240,
  parameter int BURST_LEN       = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic                   line_req,
  input  logic [9:0]             offset,
  output logic [HADDR_WIDTH-1:0] rd_addr,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  input  logic                   rd_done,
  output logic                   busy,
  output logic                   line_done,
  output logic                   frame_done,
  output logic                   line_overrun
);

  localparam logic [COL_WIDTH-1:0] LAST_COL = COL_WIDTH'(H_WORDS - BURST_LEN);
  localparam logic [COL_WIDTH-1:0] COL_STEP = COL_WIDTH'(BURST_LEN);
  localparam logic [9:0]           LAST_ROW = 10'(V_LINES - 1);

  rd_state_e              state_r;
  rd_state_e              state_nxt_s;
  logic [9:0]             row_r;
  logic [9:0]             row_nxt_s;
  logic [COL_WIDTH-1:0]   col_r;
  logic [COL_WIDTH-1:0]   col_nxt_s;
  logic [9:0]             offset_r;
  logic [9:0]             offset_nxt_s;
  logic [ROW_WIDTH-1:0]   row_sum_s;
  logic                   load_addr_s;
  logic                   accept_s;
  logic                   has_credit_s;
  logic                   empty_s;

  logic [HADDR_WIDTH-1:0] rd_addr_r;
  logic                   rd_valid_r;
  logic                   busy_r;
  logic                   line_done_r;
  logic                   frame_done_r;
  logic                   line_overrun_r;
  logic                   rd_valid_nxt_s;
  logic                   busy_nxt_s;
  logic                   line_done_nxt_s;
  logic                   frame_done_nxt_s;
  logic                   line_overrun_nxt_s;

  assign accept_s = rd_valid_r & rd_ready & (state_r == ISSUE);

  rd_credit_counter #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_credit (
    .clk        (clk),
    .rst        (rst),
    .inc        (accept_s),
    .dec        (rd_done),
    .has_credit (has_credit_s),
    .empty      (empty_s)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // next state; frame_start restarts the frame from any state
  always_comb begin
    state_nxt_s = state_r;
    if (frame_start) begin
      state_nxt_s = WAIT_LINE;
    end else begin
      case (state_r)
        IDLE:      state_nxt_s = IDLE;
        WAIT_LINE: begin
          if (line_req) state_nxt_s = ISSUE;
          else          state_nxt_s = WAIT_LINE;
        end
        ISSUE: begin
          if (accept_s && (col_r == LAST_COL)) state_nxt_s = DRAIN;
          else                                 state_nxt_s = ISSUE;
        end
        DRAIN: begin
          if (!empty_s)                state_nxt_s = DRAIN;
          else if (row_r == LAST_ROW)  state_nxt_s = IDLE;
          else                         state_nxt_s = WAIT_LINE;
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // datapath updates and next values of the registered outputs
  always_comb begin
    offset_nxt_s     = offset_r;
    row_nxt_s        = row_r;
    col_nxt_s        = col_r;
    load_addr_s      = 1'b0;
    line_done_nxt_s  = 1'b0;
    frame_done_nxt_s = 1'b0;
    if (frame_start) begin
      offset_nxt_s = offset;
      row_nxt_s    = 10'd0;
    end else begin
      case (state_r)
        WAIT_LINE: begin
          if (line_req) begin
            col_nxt_s   = {COL_WIDTH{1'b0}};
            load_addr_s = 1'b1;
          end else begin
            col_nxt_s   = col_r;
          end
        end
        ISSUE: begin
          if (accept_s) begin
            col_nxt_s   = col_r + COL_STEP;
            load_addr_s = 1'b1;
          end else begin
            col_nxt_s   = col_r;
          end
        end
        DRAIN: begin
          if (empty_s) begin
            line_done_nxt_s  = 1'b1;
            frame_done_nxt_s = (row_r == LAST_ROW);
            row_nxt_s        = row_r + 10'd1;
          end else begin
            row_nxt_s        = row_r;
          end
        end
        default: row_nxt_s = row_r;
      endcase
    end
    line_overrun_nxt_s = line_req & (frame_start | (state_r != WAIT_LINE));
    rd_valid_nxt_s     = (state_nxt_s == ISSUE) & has_credit_s;
    busy_nxt_s         = (state_nxt_s == ISSUE) | (state_nxt_s == DRAIN);
    row_sum_s          = {3'b000, row_nxt_s} + {3'b000, offset_nxt_s};
  end

  // datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset_r       <= 10'd0;
      row_r          <= 10'd0;
      col_r          <= {COL_WIDTH{1'b0}};
      rd_addr_r      <= {HADDR_WIDTH{1'b0}};
      rd_valid_r     <= 1'b0;
      busy_r         <= 1'b0;
      line_done_r    <= 1'b0;
      frame_done_r   <= 1'b0;
      line_overrun_r <= 1'b0;
    end else begin
      offset_r       <= offset_nxt_s;
      row_r          <= row_nxt_s;
      col_r          <= col_nxt_s;
      if (load_addr_s) rd_addr_r <= pack_haddr(FB_BANK, row_sum_s, col_nxt_s);
      else             rd_addr_r <= rd_addr_r;
      rd_valid_r     <= rd_valid_nxt_s;
      busy_r         <= busy_nxt_s;
      line_done_r    <= line_done_nxt_s;
      frame_done_r   <= frame_done_nxt_s;
      line_overrun_r <= line_overrun_nxt_s;
    end
  end

  assign rd_addr      = rd_addr_r;
  assign rd_valid     = rd_valid_r;
  assign busy         = busy_r;
  assign line_done    = line_done_r;
  assign frame_done   = frame_done_r;
  assign line_overrun = line_overrun_r;

endmodule

// File: tb/tb_frame_addr_reader.sv
// Scoreboard bench for frame_addr_reader: expected burst addresses are queued per line request
// and popped on every accepted read; rd_done is returned a fixed delay after accept or by hand.
module tb_frame_addr_reader;

  localparam int H  = 320;
  localparam int V  = 240;
  localparam int B  = 8;
  localparam int MX = 4;
  localparam int NB = H / B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        line_req = 1'b0;
  logic [9:0]  offset = 10'd0;
  logic        rd_ready = 1'b0;
  logic        rd_done = 1'b0;
  logic [23:0] rd_addr;
  logic        rd_valid;
  logic        busy;
  logic        line_done;
  logic        frame_done;
  logic        line_overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int ld_cnt = 0;
  int fd_cnt = 0;
  int ov_cnt = 0;
  int ld_cyc = -1;
  int fd_cyc = -1;
  int last_done_cyc = -1;
  bit auto_done = 1'b0;
  bit extra_done = 1'b0;
  int cur_row = 0;
  int cur_off = 0;
  logic [23:0] exp_q[$];
  int done_q[$];

  always #5 clk = ~clk;

  frame_addr_reader #(
    .H_WORDS(H), .V_LINES(V), .BURST_LEN(B), .MAX_OUTSTANDING(MX)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .line_req(line_req),
    .offset(offset), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_done(rd_done), .busy(busy), .line_done(line_done), .frame_done(frame_done),
    .line_overrun(line_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // advance one cycle; inputs change 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    rd_done = extra_done;
    extra_done = 1'b0;
    if (done_q.size() > 0 && done_q[0] == cyc) begin
      void'(done_q.pop_front());
      rd_done = 1'b1;
    end
    if (rd_done) last_done_cyc = cyc;
  endtask

  task automatic start_frame(input int off);
    offset = 10'(off);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    offset = ~offset;
    cur_off = off;
    cur_row = 0;
  endtask

  task automatic req_line();
    for (int i = 0; i < NB; i++)
      exp_q.push_back({2'b01, 13'(cur_row + cur_off), 9'(i * B)});
    line_req = 1'b1;
    step();
    line_req = 1'b0;
  endtask

  task automatic wait_ld(input string tag, input int bound);
    int start = ld_cnt;
    int n = 0;
    while (ld_cnt == start && n < bound) begin
      step();
      n++;
    end
    chk({tag, "_done"}, 32'(ld_cnt != start), 32'd1);
  endtask

  task automatic full_line(input string tag);
    req_line();
    wait_ld(tag, 300);
    cur_row++;
    chk({tag, "_sb"}, exp_q.size(), 32'd0);
  endtask

  task automatic drain_manual(input int n);
    rd_ready = 1'b0;
    repeat (n) begin
      extra_done = 1'b1;
      step();
    end
    step();
  endtask

  // observe accepts and pulses mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid && rd_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) chk("extra_req", 32'd1, 32'd0);
        else                   chk("rd_addr", rd_addr, exp_q.pop_front());
        if (auto_done) done_q.push_back(cyc + 3);
      end
      if (line_done) begin ld_cnt++; ld_cyc = cyc; end
      if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
      if (line_overrun) ov_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, ld0, fd0, ov0, n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", rd_valid, 32'd0);
    chk("rst_addr", rd_addr, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_ld", line_done, 32'd0);
    chk("rst_fd", frame_done, 32'd0);
    chk("rst_ovr", line_overrun, 32'd0);
    rst = 1'b0;
    step();
    step();
    chk("idle_valid", rd_valid, 32'd0);

    // single line, offset 5
    rd_ready = 1'b1;
    auto_done = 1'b1;
    start_frame(5);
    chk("ws_busy", busy, 32'd0);
    a0 = acc_cnt;
    req_line();
    chk("t1_first_valid", rd_valid, 32'd1);
    chk("t1_first_addr", rd_addr, 32'h400A00);
    chk("t1_busy", busy, 32'd1);
    wait_ld("t1_line", 300);
    cur_row++;
    chk("t1_acc", acc_cnt - a0, NB);
    chk("t1_sb", exp_q.size(), 32'd0);
    chk("t1_ld_lat", ld_cyc, last_done_cyc + 2);
    chk("t1_busy_after", busy, 32'd0);

    // credit limit; rd_done at count 0 first must be ignored
    auto_done = 1'b0;
    drain_manual(2);
    rd_ready = 1'b1;
    a0 = acc_cnt;
    req_line();
    repeat (10) step();
    chk("t2_acc4", acc_cnt - a0, 32'd4);
    chk("t2_stall", rd_valid, 32'd0);
    extra_done = 1'b1;
    step();
    step();
    chk("t2_revalid", rd_valid, 32'd1);
    repeat (6) step();
    chk("t2_acc5", acc_cnt - a0, 32'd5);
    chk("t2_stall2", rd_valid, 32'd0);

    // back-pressure on the same line
    drain_manual(4);
    chk("t3_valid", rd_valid, 32'd1);
    repeat (10) begin
      step();
      chk("t3_hold_addr", rd_addr, {2'b01, 13'(cur_row + cur_off), 9'(5 * B)});
      chk("t3_hold_valid", rd_valid, 32'd1);
    end
    chk("t3_noacc", acc_cnt - a0, 32'd5);
    rd_ready = 1'b1;
    auto_done = 1'b1;
    wait_ld("t3_line", 300);
    cur_row++;
    chk("t3_acc", acc_cnt - a0, NB);
    chk("t3_sb", exp_q.size(), 32'd0);

    // full frame at offset 1023
    start_frame(1023);
    ld0 = ld_cnt;
    fd0 = fd_cnt;
    for (int l = 0; l < V; l++) full_line("t4_line");
    chk("t4_ld", ld_cnt - ld0, V);
    chk("t4_fd", fd_cnt - fd0, 32'd1);
    chk("t4_fd_coinc", fd_cyc, ld_cyc);
    chk("t4_busy", busy, 32'd0);
    ov0 = ov_cnt;
    line_req = 1'b1;
    step();
    line_req = 1'b0;
    step();
    chk("t4_idle_ovr", ov_cnt - ov0, 32'd1);
    chk("t4_idle_novalid", rd_valid, 32'd0);

    // abort during line 7 with 3 bursts outstanding
    start_frame(5);
    for (int l = 0; l < 7; l++) full_line("t5_pre");
    ld0 = ld_cnt;
    fd0 = fd_cnt;
    auto_done = 1'b0;
    a0 = acc_cnt;
    req_line();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (rd_valid && rd_ready) n++;
      if (n == 3) break;
      step();
    end
    step();
    rd_ready = 1'b0;
    start_frame(5);
    chk("t5_valid_drop", rd_valid, 32'd0);
    chk("t5_busy", busy, 32'd0);
    chk("t5_acc3", acc_cnt - a0, 32'd3);
    exp_q.delete();
    drain_manual(3);
    repeat (3) step();
    chk("t5_no_ld", ld_cnt - ld0, 32'd0);
    chk("t5_no_fd", fd_cnt - fd0, 32'd0);
    rd_ready = 1'b1;
    a0 = acc_cnt;
    req_line();
    chk("t5_valid", rd_valid, 32'd1);
    chk("t5_row0_addr", rd_addr, 32'h400A00);
    repeat (8) step();
    chk("t5_credit4", acc_cnt - a0, 32'd4);
    drain_manual(4);
    rd_ready = 1'b1;
    auto_done = 1'b1;
    wait_ld("t5_line", 300);
    cur_row++;
    chk("t5_sb", exp_q.size(), 32'd0);

    // line_req during DRAIN
    ov0 = ov_cnt;
    a0 = acc_cnt;
    req_line();
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (rd_valid && rd_ready) n++;
      if (n == NB) break;
      step();
    end
    step();
    line_req = 1'b1;
    step();
    line_req = 1'b0;
    chk("t6_ovr_drain", line_overrun, 32'd1);
    wait_ld("t6_line", 300);
    cur_row++;
    chk("t6_acc", acc_cnt - a0, NB);
    chk("t6_sb", exp_q.size(), 32'd0);

    // frame_start together with line_req
    offset = 10'd77;
    frame_start = 1'b1;
    line_req = 1'b1;
    step();
    frame_start = 1'b0;
    line_req = 1'b0;
    cur_off = 77;
    cur_row = 0;
    chk("t6_ovr_sim", line_overrun, 32'd1);
    chk("t6_sim_novalid", rd_valid, 32'd0);
    step();
    step();
    chk("t6_sim_idle", rd_valid, 32'd0);
    chk("t6_ov_cnt", ov_cnt - ov0, 32'd2);

    // accept and rd_done in the same cycle leave the count unchanged
    auto_done = 1'b0;
    rd_ready = 1'b1;
    a0 = acc_cnt;
    req_line();
    step();
    step();
    extra_done = 1'b1;
    step();
    repeat (8) step();
    chk("t6_simul_acc", acc_cnt - a0, 32'd5);
    chk("t6_simul_stall", rd_valid, 32'd0);
    drain_manual(4);
    rd_ready = 1'b1;
    auto_done = 1'b1;
    wait_ld("t6_end", 300);
    cur_row++;
    chk("t6_end_sb", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
